cdc_word_receiver: RTL
======================

Name: cdc_word_receiver

Overview:
Receiving end of a toggle-based req/ack handshake that moves a W-bit word from a foreign clock domain into out_clk. in_req is synchronised through a flop chain, and in_data is captured once a toggle is detected. The word is presented on a valid/ready interface, and an ack toggle goes back to the source only after the local consumer accepts the word. Used between the NeXT-side serial/ASIC logic and the out_clk audio/keyboard processing.

Parameters:
W, 8, data word width
SYNC_STAGES, 2, synchroniser depth on in_req (legal 2..4)

Ports:
out_clk  input  1  receive-domain clock, all flops on posedge
reset  input  1  synchronous, active-high
in_req  input  1  request toggle from source domain, asynchronous to out_clk
in_data  input  W  source word; source holds it stable from in_req toggle until it sees out_ack toggle
out_ack  output  1  ack toggle back to source, registered
out_data  output  W  captured word
out_valid  output  1  out_data valid
out_ready  input  1  consumer accepts when out_valid && out_ready at a posedge
busy  output  1  state != IDLE
proto_err  output  1  sticky protocol-violation flag

Behaviour:
- Interface decision: reset is synchronous and active-high; the clock is out_clk.
- Reset values: sync chain 0, req_seen 0, sync_prev 0, out_ack 0, out_valid 0, out_data 0, proto_err 0, state IDLE, busy 0.
- Both domains reset together; synced level 0 is the baseline. If in_req is 1 after reset, that counts as a pending toggle and is serviced.
- Sync: in_req passes through SYNC_STAGES flops to give sync_q. Only sync_q is used by the logic, never in_req or earlier stages.
- FSM states: IDLE, CAPTURE, VALID.
  - IDLE: if sync_q != req_seen, go to CAPTURE.
  - CAPTURE, one cycle: out_data <= in_data, req_seen <= sync_q, out_valid <= 1, go to VALID.
  - VALID: out_valid and out_data held while out_ready = 0. On the edge with out_valid && out_ready: out_valid <= 0, out_ack <= ~out_ack, go to IDLE.
- Latency: if in_req changes before edge E0, the chain's first stage samples it at E0.
  - sync_q updates at E(SYNC_STAGES-1).
  - CAPTURE is entered at E(SYNC_STAGES).
  - out_valid = 1 after E(SYNC_STAGES+1). With SYNC_STAGES = 2, that is E3.
- With out_ready held at 1, out_valid is a one-cycle pulse and out_ack toggles on the same edge that out_valid falls.
- Minimum turnaround: the next transfer can only start after the source sees out_ack; the block imposes no extra idle cycles.
- Protocol error: edge = sync_q ^ sync_prev, with sync_prev <= sync_q every cycle.
  - An edge while state is CAPTURE or VALID sets proto_err = 1. It stays set until reset.
  - The late toggle is not dropped silently: req_seen mismatch in IDLE services it as a new transfer, using whatever in_data is then.
  - An even number of extra toggles is lost; proto_err still flags it.
- out_ack changes only in VALID on acceptance, so the source is never acked for an unconsumed word.
- Reset mid-transfer, in any state: next edge returns every flop to its reset value. out_ack returning to 0 is acceptable because the source is reset at the same time.
- out_data is not cleared on acceptance; it retains the last word.

Optional Feature:
CDC_RX_PARITY_EN
- Defined: extra ports in_parity (input, 1) and parity_err (output, 1, reset 0).
  - In CAPTURE, parity_err <= ^{in_data, in_parity}, i.e. even parity over W+1 bits; a nonzero result is an error.
  - parity_err updates together with out_data and is valid while out_valid = 1.
  - The word is delivered and acked regardless of parity.
- Undefined: both ports absent, no check logic.

Test Plan:
1. Reset 2 cycles; in_data = 8'hA5; toggle in_req 0->1; out_ready = 1 -> out_valid = 1 for exactly one cycle after E3, out_data = 8'hA5, out_ack 0->1 on the following edge, busy high from E2 through acceptance.
2. Backpressure: same transfer with out_ready = 0 for 10 cycles -> out_valid and out_data = 8'hA5 held for 10 cycles, out_ack unchanged; raise out_ready -> out_ack toggles on the next edge, out_valid falls.
3. Stream: source sends 8'h01, 02, 03, 04, toggling in_req on each out_ack toggle, out_ready = 1 -> four words received in order, out_ack ends at 0, proto_err = 0.
4. Violation: out_ready = 0 while out_valid = 1; toggle in_req again -> proto_err = 1 two edges later and stays 1 through acceptance; after reset, proto_err = 0.
5. Reset while out_valid = 1 -> next edge: out_valid = 0, out_ack = 0, out_data = 0, busy = 0; new toggle afterwards is received normally.
6. CDC_RX_PARITY_EN: in_data = 8'h03, in_parity = 1 -> parity_err = 1 with out_valid; in_data = 8'h03, in_parity = 0 -> parity_err = 0; both words acked.

Source files
------------

// File: rtl/cdc_word_receiver.sv
// rtl/cdc_word_receiver.sv - toggle req/ack word receiver into the out_clk domain
//
// Receives a W-bit word from a foreign clock domain using a toggle handshake.
// in_req is synchronised through SYNC_STAGES flops (legal range 2..4). When a
// new toggle is seen, in_data is captured. The word is then offered on a
// valid/ready interface. The ack toggle is returned to the source only when
// the local consumer accepts the word.
//
// Optional feature macro: CDC_RX_PARITY_EN. When defined, it adds the
// in_parity / parity_err even-parity check.
//
// Ports:
//   out_clk    in   receive-domain clock, posedge
//   reset      in   synchronous, active-high
//   in_req     in   request toggle, asynchronous to out_clk
//   in_data    in   W-bit source word, held stable until out_ack toggles
//   in_parity  in   (CDC_RX_PARITY_EN) even-parity bit over in_data
//   out_ack    out  registered ack toggle back to the source
//   out_data   out  captured word; keeps the last word after acceptance
//   out_valid  out  out_data valid
//   out_ready  in   consumer accepts on out_valid && out_ready
//   busy       out  high while a transfer is in progress (state != IDLE)
//   proto_err  out  sticky: source toggled again before being acked
//   parity_err out  (CDC_RX_PARITY_EN) parity result for the current word

module cdc_word_receiver #(
  parameter int W           = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic         out_clk,
  input  logic         reset,
  input  logic         in_req,
  input  logic [W-1:0] in_data,
`ifdef CDC_RX_PARITY_EN
  input  logic         in_parity,
  output logic         parity_err,
`endif
  output logic         out_ack,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         busy,
  output logic         proto_err
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    VALID   = 2'd2
  } state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sync_chain;
  logic                   sync_q;
  logic                   sync_prev;
  logic                   req_seen;

  // Only the last synchroniser stage may feed any logic.
  assign sync_q = sync_chain[SYNC_STAGES-1];

  always_ff @(posedge out_clk) begin
    if (reset) begin
      sync_chain <= '0;
      sync_prev  <= 1'b0;
      req_seen   <= 1'b0;
      out_ack    <= 1'b0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      proto_err  <= 1'b0;
      busy       <= 1'b0;
      state      <= IDLE;
`ifdef CDC_RX_PARITY_EN
      parity_err <= 1'b0;
`endif
    end else begin
      sync_chain <= {sync_chain[SYNC_STAGES-2:0], in_req};
      sync_prev  <= sync_q;

      // A toggle arriving while a word is still owned by this side means the
      // source did not wait for ack. The toggle is still serviced later
      // through the req_seen mismatch; an even number of toggles is lost.
      if ((sync_q ^ sync_prev) && (state != IDLE)) begin
        proto_err <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (sync_q != req_seen) begin
            state <= CAPTURE;
            busy  <= 1'b1;
          end
        end
        CAPTURE: begin
          out_data  <= in_data;
          req_seen  <= sync_q;
          out_valid <= 1'b1;
          state     <= VALID;
`ifdef CDC_RX_PARITY_EN
          parity_err <= ^{in_data, in_parity};
`endif
        end
        VALID: begin
          // Ack only after the consumer takes the word.
          if (out_ready) begin
            out_valid <= 1'b0;
            out_ack   <= ~out_ack;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule
